// File: rtl/led_pkg.sv
// Shared definitions for the LED scan controller: FSM encoding, display limits
// and the double-dabble nibble correction.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;
  localparam int CONV_STEPS  = 14;
  localparam int BIN_W       = 14;
  localparam int BCD_W       = 4 * NUM_DIGITS;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock for CONV_STEPS clocks
// after start. done is high during the cycle whose closing edge makes the last shift.
module bin2bcd_seq
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_adj = add3_nibbles(bcd_q);
    if (start && !busy_q) begin
      bin_d  = bin_in;
      bcd_d  = '0;
      cnt_d  = 4'(CONV_STEPS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d          = cnt_q - 4'd1;
      if (cnt_q == 4'd1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == 4'd1);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// 4-digit multiplexed 7-segment controller: binary capture, BCD conversion and scan.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_value,
  output logic [3:0]       bcd_out,
  output logic             digit_en,
  output logic [3:0]       an,
  output logic             ovf
);

  localparam int PW = $clog2(SCAN_DIV);

  state_e state_q, state_d;

  logic                              conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0]                  conv_bcd;
  logic [BIN_W-1:0]                  clamped;
  logic                              cap_ovf_q, cap_ovf_d;
  logic [NUM_DIGITS-1:0][3:0]        disp_q, disp_d;
  logic                              ovf_q, ovf_d;
  logic [PW-1:0]                     presc_q, presc_d;
  logic [1:0]                        idx_q, idx_d;
  logic [3:0]                        an_q, an_d;
  logic [3:0]                        bcd_q, bcd_d;
  logic                              en_q, en_d;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid && in_ready) state_d = ST_CONV;
      ST_CONV: if (conv_done)            state_d = ST_LOAD;
      ST_LOAD:                           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready   = (state_q == ST_IDLE) && !conv_busy;
    conv_start = in_valid && in_ready;
  end

  assign clamped = (in_value > BIN_W'(MAX_DISPLAY)) ? BIN_W'(MAX_DISPLAY) : in_value;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (conv_start),
    .bin_in  (clamped),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_comb begin
    cap_ovf_d = cap_ovf_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    if (conv_start) cap_ovf_d = (in_value > BIN_W'(MAX_DISPLAY));
    if (state_q == ST_LOAD) begin
      disp_d = conv_bcd;
      ovf_d  = cap_ovf_q;
    end
  end

  // Scanner runs free of the FSM; outputs are registered from the current index.
  always_comb begin
    logic [NUM_DIGITS-1:0] nz_up;
    nz_up   = '0;
    presc_d = (presc_q == PW'(SCAN_DIV - 1)) ? '0 : presc_q + PW'(1);
    idx_d   = (presc_q == PW'(SCAN_DIV - 1)) ? idx_q + 2'd1 : idx_q;
    an_d    = ~(4'b0001 << idx_q);
    bcd_d   = disp_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
    nz_up[NUM_DIGITS-1] = |disp_q[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) nz_up[i] = nz_up[i+1] | (|disp_q[i]);
    en_d = (idx_q == 2'd0) || nz_up[idx_q];
`else
    en_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_ovf_q <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1110;
      bcd_q     <= '0;
      en_q      <= 1'b1;
    end else begin
      cap_ovf_q <= cap_ovf_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
    end
  end

  assign an       = an_q;
  assign bcd_out  = bcd_q;
  assign digit_en = en_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: value-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_led_scan_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_value = '0;
  logic [3:0]  bcd_out;
  logic        digit_en;
  logic [3:0]  an;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  led_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .bcd_out  (bcd_out),
    .digit_en (digit_en),
    .an       (an),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: displayed value as an integer, scan position from edge count.
  int m_n, m_busy, m_disp, m_pend, p_idx, p_disp;
  bit m_ovf, m_povf, m_live;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_busy = 0; m_disp = 0; m_pend = 0; m_ovf = 0; m_povf = 0;
      p_idx = 0; p_disp = 0; m_live = 0;
    end else begin
      p_idx  = (m_n / SD) % 4;
      p_disp = m_disp;
      if (m_busy == 0) begin
        if (in_valid) begin
          m_pend = (int'(in_value) > 9999) ? 9999 : int'(in_value);
          m_povf = (int'(in_value) > 9999);
          m_busy = 15;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_disp = m_pend;
          m_ovf  = m_povf;
        end
      end
      m_n++;
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_an;
    int exp_en;
    if (!rst && m_live) begin
      exp_an = ~(4'b0001 << p_idx);
`ifdef LEADING_ZERO_BLANK_EN
      exp_en = (p_idx == 0 || p_disp >= pow10(p_idx)) ? 1 : 0;
`else
      exp_en = 1;
`endif
      chk("an", int'(an), int'(exp_an));
      chk("bcd_out", int'(bcd_out), (p_disp / pow10(p_idx)) % 10);
      chk("digit_en", int'(digit_en), exp_en);
      chk("in_ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
      chk("ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 14'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a fresh slot of the given digit select, so the display is settled.
  task automatic wait_an(input logic [3:0] target);
    int k = 0;
    while (an == target && k < 64) begin @(negedge clk); k++; end
    while (an != target && k < 64) begin @(negedge clk); k++; end
    if (k >= 64) chk("wait_an_timeout", int'(an), int'(target));
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) chk("wait_ready_timeout", int'(in_ready), 1);
  endtask

  initial begin
    int lowcnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_an", int'(an), 14);
    chk("rst_bcd", int'(bcd_out), 0);
    chk("rst_en", int'(digit_en), 1);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_ovf", int'(ovf), 0);

    // 1234: latency and scan order
    send(1234);
    lowcnt = 0;
    while (!in_ready && lowcnt < 100) begin lowcnt++; @(negedge clk); end
    chk("busy_cycles", lowcnt, 15);
    wait_an(4'b1110); chk("d0_1234", int'(bcd_out), 4);
    wait_an(4'b1011); chk("d2_1234", int'(bcd_out), 2);
    wait_an(4'b0111); chk("d3_1234", int'(bcd_out), 1);

    // overflow clamps, then a small value clears ovf
    send(12000);
    wait_ready();
    @(negedge clk);
    chk("ovf_12000", int'(ovf), 1);
    wait_an(4'b1011); chk("d2_12000", int'(bcd_out), 9);
    send(5);
    wait_ready();
    @(negedge clk);
    chk("ovf_5", int'(ovf), 0);
    wait_an(4'b1110); chk("d0_5", int'(bcd_out), 5);
    wait_an(4'b1101); chk("d1_5", int'(bcd_out), 0);

    // in_valid held during CONV is ignored until IDLE
    send(1234);
    in_valid = 1'b1;
    in_value = 14'd42;
    repeat (14) @(negedge clk);
    chk("ready_mid", int'(in_ready), 0);
    @(negedge clk);
    chk("ready_back", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_42", int'(in_ready), 0);
    wait_ready();
    wait_an(4'b1110); chk("d0_42", int'(bcd_out), 2);
    wait_an(4'b1101); chk("d1_42", int'(bcd_out), 4);
    wait_an(4'b1011); chk("d2_42", int'(bcd_out), 0);

    // reset in the middle of converting 8000
    send(8000);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_an", int'(an), 14);
    chk("abort_ready", int'(in_ready), 1);
    chk("abort_bcd", int'(bcd_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    wait_an(4'b0111); chk("d3_abort", int'(bcd_out), 0);

    // 7: blanking behaviour depends on build
    send(7);
    wait_ready();
    wait_an(4'b1110);
    chk("d0_7", int'(bcd_out), 7);
    chk("en0_7", int'(digit_en), 1);
    wait_an(4'b1101);
    chk("d1_7", int'(bcd_out), 0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("en1_7", int'(digit_en), 0);
`else
    chk("en1_7", int'(digit_en), 1);
`endif
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
